// File: rtl/axis_if.sv
// ---------------------------------------------------------------------------
// axis_if -- minimal AXI-Stream interface shared by stream-connected units.
//
// Parameter
//   TDATA_WIDTH : payload width in bits
// Signals
//   tvalid : producer has a beat on tdata
//   tready : consumer can take a beat this cycle
//   tdata  : beat payload
// Modports
//   m : master side (drives tvalid/tdata, samples tready)
//   s : slave side  (samples tvalid/tdata, drives tready)
// ---------------------------------------------------------------------------
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);

endinterface : axis_if

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice -- full-throughput AXI-Stream register slice.
//
// Breaks the combinational valid, ready and data paths between a producer
// and a consumer. Holds at most two beats: the output register, which drives
// the downstream port directly, and a skid register that catches the beat
// accepted in the same cycle the consumer first stalls.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   axis_sif   : upstream (slave) stream port
//   axis_mif   : downstream (master) stream port, same width as axis_sif
//   invalidate : synchronous flush, discards every held beat
// ---------------------------------------------------------------------------
module axis_reg_slice (
  input  logic clk,
  input  logic rst,
  axis_if.s    axis_sif,
  axis_if.m    axis_mif,
  input  logic invalidate
);

  // Payload width comes from the connected interface instance.
  localparam int TDATA_WIDTH = $bits(axis_sif.tdata);

  logic                   out_valid_q;
  logic [TDATA_WIDTH-1:0] out_data_q;
  logic                   skid_valid_q;
  logic [TDATA_WIDTH-1:0] skid_data_q;

  logic w_push;
  logic w_pop;
  logic w_out_free;

  // Ready depends only on the skid register, so no combinational path runs
  // from the consumer's tready back to the producer. The reset term keeps the
  // producer from handing over beats while the slice is held in reset.
  assign axis_sif.tready = rst & ~skid_valid_q;

  assign w_push     = axis_sif.tvalid & axis_sif.tready;
  assign w_pop      = out_valid_q & axis_mif.tready;
  assign w_out_free = ~out_valid_q | w_pop;

  assign axis_mif.tvalid = out_valid_q;
  assign axis_mif.tdata  = out_data_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let the skid-to-output
  // move see the already-updated skid flag.
  // NOTE: the data registers are reset as well, so tdata reads as zero out of
  // reset rather than X; they are two words, not a memory, so this is cheap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (invalidate) begin
      // Data registers are left as they are; only the valid flags matter.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        // The skid beat is older than anything upstream; tready is low
        // here, so no push can compete with it.
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (w_push) begin
        out_valid_q <= 1'b1;
        out_data_q  <= axis_sif.tdata;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (w_push) begin
      // Output is stalled: park the beat accepted this cycle.
      skid_valid_q <= 1'b1;
      skid_data_q  <= axis_sif.tdata;
    end
  end

endmodule : axis_reg_slice

// File: tb/tb_axis_reg_slice.sv
// ---------------------------------------------------------------------------
// tb_axis_reg_slice -- self-checking bench for axis_reg_slice.
//
// Accepted beats are queued as expected output when the producer handshake
// is seen; an independent monitor pops and compares on every downstream
// handshake and checks that a stalled beat stays stable.
// ---------------------------------------------------------------------------
module tb_axis_reg_slice;

  localparam int W = 16;

  logic clk        = 1'b0;
  logic rst        = 1'b0;
  logic invalidate = 1'b0;

  axis_if #(.TDATA_WIDTH(W)) sif ();
  axis_if #(.TDATA_WIDTH(W)) mif ();

  axis_reg_slice dut (
    .clk        (clk),
    .rst        (rst),
    .axis_sif   (sif),
    .axis_mif   (mif),
    .invalidate (invalidate)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  bit           prod_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; queue it as expected output once the handshake is seen.
  task automatic send_beat(input logic [W-1:0] d);
    sif.tvalid = 1'b1;
    sif.tdata  = d;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sif.tready === 1'b1) begin
        sb.push_back(d);
        @(posedge clk);
        #1;
        sif.tvalid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: tready stuck at 0 for beat 0x%0h, expected 1", d);
    sif.tvalid = 1'b0;
  endtask

  // Monitor: ordering/loss/duplication and stability of a stalled beat.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic [W-1:0] exp_d;

  always @(negedge clk) begin
    if (rst && prev_stall) begin
      n_vec++;
      if (!(mif.tvalid === 1'b1 && mif.tdata === prev_data)) begin
        n_err++;
        $display("FAIL hold_stable: tvalid=%b tdata=0x%0h, expected tvalid=1 tdata=0x%0h",
                 mif.tvalid, mif.tdata, prev_data);
      end
    end
    if (rst && !invalidate && mif.tvalid === 1'b1 && mif.tready === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", mif.tdata);
      end else begin
        exp_d = sb.pop_front();
        if (mif.tdata !== exp_d) begin
          n_err++;
          $display("FAIL beat_order: got 0x%0h, expected 0x%0h", mif.tdata, exp_d);
        end
      end
    end
    prev_stall = rst && !invalidate && mif.tvalid === 1'b1 && mif.tready === 1'b0;
    prev_data  = mif.tdata;
  end

  initial begin
    sif.tvalid = 1'b0;
    sif.tdata  = '0;
    mif.tready = 1'b0;

    // ---- reset then idle ----
    #2;
    check("rst_tvalid", {31'd0, mif.tvalid}, 32'd0);
    check("rst_tready", {31'd0, sif.tready}, 32'd0);
    check("rst_tdata",  {16'd0, mif.tdata},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    check("release_tready", {31'd0, sif.tready}, 32'd1);
    check("release_tvalid", {31'd0, mif.tvalid}, 32'd0);

    // ---- streaming, one cycle latency, back-to-back ----
    mif.tready = 1'b1;
    send_beat(16'h0011);
    check("stream_v1", {31'd0, mif.tvalid}, 32'd1);
    check("stream_d1", {16'd0, mif.tdata},  32'h11);
    send_beat(16'h0022);
    check("stream_d2", {16'd0, mif.tdata},  32'h22);
    send_beat(16'h0033);
    check("stream_d3", {16'd0, mif.tdata},  32'h33);
    check("stream_rdy", {31'd0, sif.tready}, 32'd1);
    tick();
    check("stream_idle", {31'd0, mif.tvalid}, 32'd0);

    // ---- stall with skid capture ----
    mif.tready = 1'b0;
    send_beat(16'h000A);
    check("stall_d_a",     {16'd0, mif.tdata},  32'hA);
    check("stall_rdy_one", {31'd0, sif.tready}, 32'd1);
    send_beat(16'h000B);
    check("stall_rdy_low", {31'd0, sif.tready}, 32'd0);
    check("stall_hold_a",  {16'd0, mif.tdata},  32'hA);
    repeat (3) tick();
    check("stall_still_a", {16'd0, mif.tdata},  32'hA);
    check("stall_rdy_low2", {31'd0, sif.tready}, 32'd0);
    mif.tready = 1'b1;
    tick();
    check("unstall_d_b",   {16'd0, mif.tdata},  32'hB);
    check("ready_return",  {31'd0, sif.tready}, 32'd1);
    tick();
    check("unstall_idle",  {31'd0, mif.tvalid}, 32'd0);

    // ---- flush with two beats held ----
    mif.tready = 1'b0;
    send_beat(16'h005A);
    send_beat(16'h005B);
    check("flush_full", {31'd0, sif.tready}, 32'd0);
    invalidate = 1'b1;
    sif.tvalid = 1'b1;
    sif.tdata  = 16'h00EE;
    tick();
    invalidate = 1'b0;
    sif.tvalid = 1'b0;
    sb.delete();
    check("flush_tvalid", {31'd0, mif.tvalid}, 32'd0);
    check("flush_tready", {31'd0, sif.tready}, 32'd1);

    // ---- flush with a push in the same cycle ----
    send_beat(16'h0061);
    invalidate = 1'b1;
    sif.tvalid = 1'b1;
    sif.tdata  = 16'h0077;
    tick();
    invalidate = 1'b0;
    sif.tvalid = 1'b0;
    sb.delete();
    check("flush_push_tvalid", {31'd0, mif.tvalid}, 32'd0);
    mif.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_push_gone", {31'd0, mif.tvalid}, 32'd0);
    end

    // ---- random valid/ready against the queue model ----
    prod_done = 1'b0;
    fork
      begin
        logic [W-1:0] seq;
        seq = 16'h1000;
        for (int c = 0; c < 6000; c++) begin
          if ($urandom_range(3) == 0) begin
            tick();
          end else begin
            send_beat(seq);
            seq++;
          end
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          tick();
          mif.tready = ($urandom_range(9) < 6);
        end
        mif.tready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    check("random_drain", sb.size(), 32'd0);
    tick();
    check("random_idle", {31'd0, mif.tvalid}, 32'd0);

    // ---- async reset mid-stall ----
    mif.tready = 1'b0;
    send_beat(16'h00C1);
    send_beat(16'h00C2);
    tick();
    #2 rst = 1'b0;
    #1;
    check("async_tvalid", {31'd0, mif.tvalid}, 32'd0);
    check("async_tready", {31'd0, sif.tready}, 32'd0);
    check("async_tdata",  {16'd0, mif.tdata},  32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    check("async_release", {31'd0, sif.tready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_axis_reg_slice
